// File: rtl/loop_driver_deadtime.sv
// loop_driver_deadtime
// Dead-time and non-overlap controller for the step-down half-bridge driver.
// It turns the loop PWM request into a top-switch command and the two inputs
// of the bottom-driver NAND2. Between any top-on and bottom-on interval there
// is at least one cycle with both switches off. The following are added on top:
// a programmable dead time in each direction, a minimum top on-time, diode
// emulation on zero-cross, and a sticky fault shutdown.
//
// All outputs are registered and decoded from the next state, so every output
// changes on the same clock edge as the state register.

module loop_driver_deadtime #(
   parameter int CW     = 6,
   parameter int MIN_ON = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          CELV,
   input  logic          CELG,
   input  logic          SUB,
   input  logic          en,
   input  logic          pwm,
   input  logic          zcd,
   input  logic          dcm_en,
   input  logic          flt,
   input  logic [CW-1:0] dt_tb,
   input  logic [CW-1:0] dt_bt,
   output logic          top_on,
   output logic          bot_i0,
   output logic          bot_i1,
   output logic          flt_latched,
   output logic          dead
);

   // The min-on counter holds MIN_ON-1 down to 0. MIN_ON=1 still needs a
   // one-bit counter so the register never has zero width.
   localparam int MW = (MIN_ON > 1) ? $clog2(MIN_ON) : 1;
   localparam logic [MW-1:0] MIN_ON_LOAD = MW'(MIN_ON - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DT_BT = 3'd1,
      TOP   = 3'd2,
      DT_TB = 3'd3,
      BOT   = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_nextState;
   logic [CW-1:0] r_dtCnt;
   logic [CW-1:0] w_dtCntNext;
   logic [MW-1:0] r_minOnCnt;
   logic [MW-1:0] w_minOnCntNext;

   logic          w_fltNext;
   logic          w_shutdown;
   logic          w_zeroCross;
   logic [CW-1:0] w_dtBtLoad;
   logic [CW-1:0] w_dtTbLoad;
   logic          w_unusedPins;

   // The supply, ground and substrate pins exist only so the netlist is
   // complete. They are folded into a dummy net and have no logic function.
   assign w_unusedPins = &{1'b0, CELV, CELG, SUB};

   // A dead-time state runs max(dt,1) cycles, counting from N-1 down to 0.
   // A trim of zero therefore still gives one full dead cycle.
   assign w_dtBtLoad = (dt_bt == '0) ? '0 : dt_bt - CW'(1);
   assign w_dtTbLoad = (dt_tb == '0) ? '0 : dt_tb - CW'(1);

   // The fault flag sets on any flt cycle. It clears only on a cycle with
   // en low and flt low, which is the same as keeping it only while en stays high.
   assign w_fltNext   = flt | (flt_latched & en);

   // Shutdown bypasses all dead-time sequencing. The drive is dropped on the
   // same edge that samples the disable or fault.
   assign w_shutdown  = ~en | w_fltNext;
   assign w_zeroCross = dcm_en & zcd;

   // Next-state and counter decode for the half-bridge sequencer
   always_comb begin
      w_nextState    = r_state;
      w_dtCntNext    = r_dtCnt;
      w_minOnCntNext = r_minOnCnt;

      if (w_shutdown) begin
         w_nextState    = IDLE;
         w_dtCntNext    = '0;
         w_minOnCntNext = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (pwm) begin
                  w_nextState = DT_BT;
                  w_dtCntNext = w_dtBtLoad;
               end
            end

            DT_BT: begin
               if (r_dtCnt == '0) begin
                  w_nextState    = TOP;
                  w_minOnCntNext = MIN_ON_LOAD;
               end else begin
                  w_dtCntNext = r_dtCnt - CW'(1);
               end
            end

            TOP: begin
               // A pwm fall before min-on expiry is ignored here. pwm is looked
               // at again on each cycle once the counter has reached zero.
               if (r_minOnCnt != '0) begin
                  w_minOnCntNext = r_minOnCnt - MW'(1);
               end else if (!pwm) begin
                  w_nextState = DT_TB;
                  w_dtCntNext = w_dtTbLoad;
               end
            end

            DT_TB: begin
               if (r_dtCnt != '0) begin
                  w_dtCntNext = r_dtCnt - CW'(1);
               end else if (pwm) begin
                  w_nextState = DT_BT;
                  w_dtCntNext = w_dtBtLoad;
               end else if (w_zeroCross) begin
                  w_nextState = IDLE;
               end else begin
                  w_nextState = BOT;
               end
            end

            BOT: begin
               // A new top request wins over a zero-cross seen on the same cycle
               if (pwm) begin
                  w_nextState = DT_BT;
                  w_dtCntNext = w_dtBtLoad;
               end else if (w_zeroCross) begin
                  w_nextState = IDLE;
               end
            end

            default: begin
               w_nextState = IDLE;
            end
         endcase
      end
   end

   // State, counters and registered drive outputs decoded from the next state
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= IDLE;
         r_dtCnt     <= '0;
         r_minOnCnt  <= '0;
         top_on      <= 1'b0;
         bot_i0      <= 1'b0;
         bot_i1      <= 1'b0;
         flt_latched <= 1'b0;
         dead        <= 1'b0;
      end else begin
         r_state     <= w_nextState;
         r_dtCnt     <= w_dtCntNext;
         r_minOnCnt  <= w_minOnCntNext;
         top_on      <= (w_nextState == TOP);
         bot_i0      <= (w_nextState == BOT);
         dead        <= (w_nextState == DT_BT) || (w_nextState == DT_TB);
         flt_latched <= w_fltNext;
         bot_i1      <= en & ~flt_latched & ~flt;
      end
   end

endmodule

// File: tb/tb_loop_driver_deadtime.sv
// tb_loop_driver_deadtime
// Scoreboard bench for loop_driver_deadtime. A stimulus process drives the
// inputs on the falling edge and runs a behavioural model of the controller.
// The model is written in terms of phases and elapsed-cycle counts. It pushes
// the outputs expected after the next rising edge into a queue. A monitor
// samples the DUT shortly after each rising edge and checks it against the
// queue head.

module tb_loop_driver_deadtime;

   localparam int CW     = 6;
   localparam int MIN_ON = 4;

   localparam int PH_IDLE   = 0;
   localparam int PH_TO_TOP = 1;
   localparam int PH_TOP    = 2;
   localparam int PH_TO_BOT = 3;
   localparam int PH_BOT    = 4;

   typedef struct packed {
      logic top;
      logic bot0;
      logic bot1;
      logic fl;
      logic dead;
   } outs_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          en = 1'b0, pwm = 1'b0, zcd = 1'b0, dcm_en = 1'b0, flt = 1'b0;
   logic [CW-1:0] dt_tb = '0, dt_bt = '0;
   logic          top_on, bot_i0, bot_i1, flt_latched, dead;

   // Stimulus values that applyStimulus puts onto the pins
   logic          sRst = 1'b1, sEn = 1'b0, sPwm = 1'b0, sZcd = 1'b0, sDcm = 1'b0, sFlt = 1'b0;
   logic [CW-1:0] sDtTb = '0, sDtBt = '0;

   // Reference model state
   int   mPhase   = PH_IDLE;
   int   mElapsed = 0;
   int   mDeadLen = 1;
   int   mTopAge  = 0;
   logic mFl      = 1'b0;
   logic mI1      = 1'b0;

   outs_t expQ[$];
   int    nCompared   = 0;
   int    nMismatched = 0;

   loop_driver_deadtime #(.CW(CW), .MIN_ON(MIN_ON)) dut (
      .CLK(CLK), .RST(RST), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
      .en(en), .pwm(pwm), .zcd(zcd), .dcm_en(dcm_en), .flt(flt),
      .dt_tb(dt_tb), .dt_bt(dt_bt),
      .top_on(top_on), .bot_i0(bot_i0), .bot_i1(bot_i1),
      .flt_latched(flt_latched), .dead(dead)
   );

   // Free-running controller clock
   always #5 CLK = ~CLK;

   // Opens a dead interval of max(dt,1) cycles, with the current cycle as its first
   task automatic enterDead(input int ph, input logic [CW-1:0] dt);
      mPhase   = ph;
      mDeadLen = (dt == 0) ? 1 : int'(dt);
      mElapsed = 1;
   endtask

   // Advances the model by one rising edge using the current stimulus
   task automatic modelStep();
      logic flNew;
      if (sRst) begin
         mPhase = PH_IDLE;
         mFl    = 1'b0;
         mI1    = 1'b0;
         return;
      end
      flNew = sFlt ? 1'b1 : (!sEn ? 1'b0 : mFl);
      mI1   = sEn && !mFl && !sFlt;
      mFl   = flNew;
      if (!sEn || flNew) begin
         mPhase = PH_IDLE;
         return;
      end
      case (mPhase)
         PH_IDLE: if (sPwm) enterDead(PH_TO_TOP, sDtBt);
         PH_TO_TOP: begin
            if (mElapsed >= mDeadLen) begin
               mPhase  = PH_TOP;
               mTopAge = 1;
            end else mElapsed++;
         end
         PH_TOP: begin
            if (mTopAge >= MIN_ON && !sPwm) enterDead(PH_TO_BOT, sDtTb);
            else mTopAge++;
         end
         PH_TO_BOT: begin
            if (mElapsed < mDeadLen) mElapsed++;
            else if (sPwm) enterDead(PH_TO_TOP, sDtBt);
            else if (sDcm && sZcd) mPhase = PH_IDLE;
            else mPhase = PH_BOT;
         end
         default: begin
            if (sPwm) enterDead(PH_TO_TOP, sDtBt);
            else if (sDcm && sZcd) mPhase = PH_IDLE;
         end
      endcase
   endtask

   // Drives the stimulus for n cycles and queues the expected response for each
   task automatic applyStimulus(input int n);
      outs_t e;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RST = sRst; en = sEn; pwm = sPwm; zcd = sZcd; dcm_en = sDcm; flt = sFlt;
         dt_tb = sDtTb; dt_bt = sDtBt;
         modelStep();
         e.top  = (mPhase == PH_TOP);
         e.bot0 = (mPhase == PH_BOT);
         e.bot1 = mI1;
         e.fl   = mFl;
         e.dead = (mPhase == PH_TO_TOP) || (mPhase == PH_TO_BOT);
         expQ.push_back(e);
      end
   endtask

   // Compares one sampled output set with its expected value and checks the overlap rule
   task automatic checkOutput(input outs_t act, input outs_t exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL outs @%0t: got top/bot0/bot1/fl/dead=%b required %b", $time, act, exp);
      end
      nCompared++;
      if ((act.top & act.bot0) !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL overlap @%0t: got top&bot0=%b required 0", $time, act.top & act.bot0);
      end
   endtask

   // Monitor: pops one expectation per rising edge once the stimulus has queued it
   initial begin
      outs_t act, exp;
      forever begin
         @(posedge CLK);
         #1;
         if (expQ.size() > 0) begin
            exp = expQ.pop_front();
            act = {top_on, bot_i0, bot_i1, flt_latched, dead};
            checkOutput(act, exp);
         end
      end
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      sRst = 1'b1; sDtBt = 6'd3; sDtTb = 6'd2;
      applyStimulus(3);
      sRst = 1'b0; sEn = 1'b1;
      applyStimulus(6);

      // pwm rise with dt_bt=3, then a one-cycle pwm dip inside min-on
      sPwm = 1'b1; applyStimulus(4);
      sPwm = 1'b0; applyStimulus(1);
      sPwm = 1'b1; applyStimulus(6);
      sPwm = 1'b0; applyStimulus(8);

      // Diode emulation: zcd in BOT goes idle, then zcd is ignored with dcm off
      sDcm = 1'b1; sZcd = 1'b1; applyStimulus(1);
      sZcd = 1'b0; applyStimulus(2);
      sPwm = 1'b1; applyStimulus(8);
      sPwm = 1'b0; applyStimulus(10);
      sDcm = 1'b0; sZcd = 1'b1; applyStimulus(3);
      sZcd = 1'b0;

      // Fault in TOP, latch held through pwm toggling, cleared by en low
      sPwm = 1'b1; applyStimulus(6);
      sFlt = 1'b1; applyStimulus(1);
      sFlt = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sPwm = ~sPwm; applyStimulus(1);
      end
      sEn = 1'b0; applyStimulus(1);
      sEn = 1'b1; sPwm = 1'b1; applyStimulus(8);

      // Reset in the middle of a long top-to-bottom dead time
      sDtTb = 6'd20; sPwm = 1'b0; applyStimulus(5);
      sRst = 1'b1; applyStimulus(1);
      sRst = 1'b0; applyStimulus(30);

      // Zero dead-time trims with random pwm
      sDtTb = '0; sDtBt = '0;
      for (int i = 0; i < 1000; i++) begin
         sPwm = 1'($urandom_range(0, 1));
         applyStimulus(1);
      end

      // Fully randomized traffic
      for (int i = 0; i < 3000; i++) begin
         sRst = ($urandom_range(0, 299) == 0);
         sEn  = ($urandom_range(0, 199) != 0);
         sFlt = ($urandom_range(0, 249) == 0);
         sZcd = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 5) == 0) sPwm = ~sPwm;
         if ($urandom_range(0, 49) == 0) sDcm = ~sDcm;
         if ($urandom_range(0, 19) == 0) begin
            sDtTb = CW'($urandom_range(0, 5));
            sDtBt = CW'($urandom_range(0, 5));
         end
         applyStimulus(1);
      end

      repeat (4) @(posedge CLK);
      #2;
      if (expQ.size() != 0) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL drain: got %0d pending expectations required 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
